// File: rtl/cpu_reset_pkg.sv
// Shared types and default parameters for the CPU reset sequencer.
package cpu_reset_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } rst_state_t;

  localparam int unsigned DefaultNumDomains = 4;
  localparam int unsigned DefaultStretchW   = 7;
  localparam int unsigned DefaultStageGap   = 4;
  localparam int unsigned DefaultSyncStages = 2;
  localparam int unsigned DefaultTimeoutW   = 8;

endpackage

// File: rtl/reset_sync.sv
// Async-assert, sync-deassert reset synchroniser; output is active-low.
module reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic sync_rst_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_reset_seq.sv
// CPU reset sequencer: stretches aresetn, releases domains in staggered order, handles warm reset.
module cpu_reset_seq
  import cpu_reset_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = DefaultNumDomains,
  parameter int unsigned STRETCH_W   = DefaultStretchW,
  parameter int unsigned STAGE_GAP   = DefaultStageGap,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned TIMEOUT_W   = DefaultTimeoutW
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   soft_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_idle,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   all_released,
  output logic                   soft_rst_ack,
  output logic                   drain_timeout,
  output logic                   busy
);

  localparam int unsigned DomW = $clog2(NUM_DOMAINS) + 1;
  localparam int unsigned GapW = $clog2(STAGE_GAP) + 1;

  localparam logic [STRETCH_W-1:0] StretchLast = '1;
  localparam logic [TIMEOUT_W-1:0] TimeoutLast = '1;
  localparam logic [DomW-1:0]      DomEnd      = DomW'(NUM_DOMAINS);
  localparam logic [GapW-1:0]      GapLast     = GapW'(STAGE_GAP - 1);

  logic run;

  rst_state_t             state_q, state_d;
  logic [STRETCH_W-1:0]   stretch_q, stretch_d;
  logic [DomW-1:0]        dom_q, dom_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [TIMEOUT_W-1:0]   timeout_q, timeout_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ack_q, ack_d;
  logic                   tmo_q, tmo_d;
  logic                   rel_q, busy_q;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk        (aclk),
    .arst_n     (aresetn),
    .sync_rst_n (run)
  );

  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    dom_d     = dom_q;
    gap_d     = gap_q;
    timeout_d = timeout_q;
    rst_d     = rst_q;
    ack_d     = 1'b0;
    tmo_d     = 1'b0;

    unique case (state_q)
      ASSERT: begin
        rst_d = '0;
        if (stretch_q == StretchLast) begin
          state_d   = RELEASE;
          stretch_d = '0;
          dom_d     = '0;
          gap_d     = '0;
        end else begin
          stretch_d = stretch_q + 1'b1;
        end
      end

      RELEASE: begin
        if (dom_q == DomEnd) begin
          state_d = RUN;
        end else if ((dom_q == '0) || (gap_q == GapLast)) begin
          // First domain goes immediately; later ones wait STAGE_GAP cycles each.
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (dom_q == DomW'(i)) begin
              rst_d[i] = 1'b1;
            end
          end
          dom_d = dom_q + 1'b1;
          gap_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      RUN: begin
        if (soft_rst_req) begin
          state_d   = DRAIN;
          timeout_d = '0;
        end
      end

      DRAIN: begin
        timeout_d = timeout_q + 1'b1;
        // Idle exit is checked first so it wins a tie with the timeout.
        if (&domain_idle) begin
          state_d   = ASSERT;
          rst_d     = '0;
          ack_d     = 1'b1;
          timeout_d = '0;
        end else if (timeout_q == TimeoutLast) begin
          state_d   = ASSERT;
          rst_d     = '0;
          ack_d     = 1'b1;
          tmo_d     = 1'b1;
          timeout_d = '0;
        end
      end

      default: begin
        state_d = ASSERT;
        rst_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ASSERT;
      stretch_q <= '0;
      dom_q     <= '0;
      gap_q     <= '0;
      timeout_q <= '0;
      rst_q     <= '0;
      ack_q     <= 1'b0;
      tmo_q     <= 1'b0;
      rel_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else if (run) begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      dom_q     <= dom_d;
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
      rst_q     <= rst_d;
      ack_q     <= ack_d;
      tmo_q     <= tmo_d;
      rel_q     <= (state_d == RUN);
      busy_q    <= (state_d != RUN);
    end
  end

  assign rst_n_o       = rst_q;
  assign all_released  = rel_q;
  assign soft_rst_ack  = ack_q;
  assign drain_timeout = tmo_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Bench for cpu_reset_seq: default build against a timeline model, plus a small directed build.
module tb_cpu_reset_seq;

  localparam int N    = 4;
  localparam int SW   = 7;
  localparam int GAP  = 4;
  localparam int SYNC = 2;
  localparam int TW   = 8;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         soft_rst_req = 1'b0;
  logic [N-1:0] domain_idle = '1;
  logic [N-1:0] rst_n_o;
  logic         all_released, soft_rst_ack, drain_timeout, busy;

  logic         aresetn_s = 1'b0;
  logic         soft_s = 1'b0;
  logic [0:0]   idle_s = 1'b1;
  logic [0:0]   rst_s;
  logic         all_s, ack_s, tmo_s, busy_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  cpu_reset_seq #(
    .NUM_DOMAINS (N),
    .STRETCH_W   (SW),
    .STAGE_GAP   (GAP),
    .SYNC_STAGES (SYNC),
    .TIMEOUT_W   (TW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .soft_rst_req  (soft_rst_req),
    .domain_idle   (domain_idle),
    .rst_n_o       (rst_n_o),
    .all_released  (all_released),
    .soft_rst_ack  (soft_rst_ack),
    .drain_timeout (drain_timeout),
    .busy          (busy)
  );

  cpu_reset_seq #(
    .NUM_DOMAINS (1),
    .STRETCH_W   (3),
    .STAGE_GAP   (1),
    .SYNC_STAGES (2),
    .TIMEOUT_W   (8)
  ) dut_small (
    .aclk          (aclk),
    .aresetn       (aresetn_s),
    .soft_rst_req  (soft_s),
    .domain_idle   (idle_s),
    .rst_n_o       (rst_s),
    .all_released  (all_s),
    .soft_rst_ack  (ack_s),
    .drain_timeout (tmo_s),
    .busy          (busy_s)
  );

  // Timeline model: each sequence is anchored at x_edge, the edge after which ASSERT is
  // observed; domain k is observed released (2^SW + 1 + k*GAP) edges later.
  int   ecnt = 0;
  int   x_edge = 1 << 30;
  int   d0 = 0;
  int   rb;
  bit   m_drain = 0, m_soft = 0, m_tmo = 0, prev_all;
  logic [N-1:0] exp_rst = '0;
  logic exp_all = 1'b0, exp_ack = 1'b0, exp_tmo = 1'b0, exp_busy = 1'b1;

  always @(posedge aclk) begin
    prev_all = exp_all;
    ecnt++;
    if (!aresetn) begin
      m_drain = 0; m_soft = 0; m_tmo = 0;
      x_edge  = ecnt + SYNC;
    end else if (!m_drain && prev_all && soft_rst_req) begin
      m_drain = 1;
      d0      = ecnt;
    end else if (m_drain) begin
      if (&domain_idle) begin
        m_drain = 0; m_soft = 1; m_tmo = 0; x_edge = ecnt;
      end else if (ecnt - d0 - 1 == (1 << TW) - 1) begin
        m_drain = 0; m_soft = 1; m_tmo = 1; x_edge = ecnt;
      end
    end
    if (m_drain || !aresetn) begin
      exp_rst = m_drain ? '1 : '0;
      exp_all = 1'b0;
      exp_ack = 1'b0;
      exp_tmo = 1'b0;
    end else begin
      rb = x_edge + (1 << SW) + 1;
      for (int k = 0; k < N; k++) exp_rst[k] = (ecnt >= rb + k * GAP);
      exp_all = (ecnt >= rb + (N - 1) * GAP + 1);
      exp_ack = m_soft && (ecnt == x_edge);
      exp_tmo = m_tmo && (ecnt == x_edge);
    end
    exp_busy = !exp_all;
  end

  logic [N+3:0] obs_vec, exp_vec;
  assign obs_vec = {rst_n_o, all_released, soft_rst_ack, drain_timeout, busy};
  assign exp_vec = {exp_rst, exp_all, exp_ack, exp_tmo, exp_busy};

  function automatic logic [N-1:0] rand_not_idle();
    logic [N-1:0] v;
    v = N'($urandom_range(0, (1 << N) - 2));
    return v;
  endfunction

  task automatic test_reset();
    int first_b0 = -1;
    int first_all = -1;
    aresetn = 1'b0; soft_rst_req = 1'b0; domain_idle = '1;
    repeat (3) @(posedge aclk);
    #1;
    n_tests++;
    if (obs_vec !== {{N{1'b0}}, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b", obs_vec, {{N{1'b0}}, 4'b0001});
    end
    aresetn = 1'b1;
    for (int e = 0; e < 150; e++) begin
      @(posedge aclk); #1;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL poweron cyc %0d: got %b expected %b", e + 1, obs_vec, exp_vec);
      end
      if (rst_n_o[0] === 1'b1 && first_b0 < 0) first_b0 = e + 1;
      if (all_released === 1'b1 && first_all < 0) first_all = e + 1;
    end
    n_tests++;
    if (first_b0 != 131) begin
      n_fail++;
      $display("FAIL poweron_bit0_cycle: got %0d expected 131", first_b0);
    end
    n_tests++;
    if (first_all != 144) begin
      n_fail++;
      $display("FAIL poweron_all_cycle: got %0d expected 144", first_all);
    end
  endtask

  task automatic test_async_mid_release();
    bit hit = 0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int e = 0; e < 200 && !hit; e++) begin
      @(posedge aclk); #1;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL async_pre cyc %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
      if (rst_n_o === 4'b0011) hit = 1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL async_reach_0011: got %b expected 0011", rst_n_o);
    end
    #3 aresetn = 1'b0;
    #1;
    n_tests++;
    if (obs_vec !== {{N{1'b0}}, 4'b0001}) begin
      n_fail++;
      $display("FAIL async_assert: got %b expected %b", obs_vec, {{N{1'b0}}, 4'b0001});
    end
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int e = 0; e < 150; e++) begin
      @(posedge aclk); #1;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL async_rerelease cyc %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_soft_idle();
    domain_idle = '1;
    soft_rst_req = 1'b1;
    @(posedge aclk); #1;
    soft_rst_req = 1'b0;
    n_tests++;
    if ({all_released, busy, rst_n_o} !== {2'b01, {N{1'b1}}}) begin
      n_fail++;
      $display("FAIL soft_idle_drain: got %b expected %b", {all_released, busy, rst_n_o},
               {2'b01, {N{1'b1}}});
    end
    @(posedge aclk); #1;
    n_tests++;
    if ({soft_rst_ack, drain_timeout, rst_n_o} !== {2'b10, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL soft_idle_ack: got %b expected %b", {soft_rst_ack, drain_timeout, rst_n_o},
               {2'b10, {N{1'b0}}});
    end
    for (int e = 0; e < 150; e++) begin
      @(posedge aclk); #1;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL soft_idle cyc %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_soft_timeout();
    int ack_at = -1;
    domain_idle = rand_not_idle();
    soft_rst_req = 1'b1;
    for (int e = 1; e <= 300 && ack_at < 0; e++) begin
      @(posedge aclk); #1;
      soft_rst_req = 1'b0;
      domain_idle = rand_not_idle();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL timeout cyc %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
      if (soft_rst_ack === 1'b1) begin
        ack_at = e;
        n_tests++;
        if (drain_timeout !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_flag: got %b expected 1", drain_timeout);
        end
      end
    end
    n_tests++;
    if (ack_at != 257) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d expected 257", ack_at);
    end
    domain_idle = '1;
    for (int e = 0; e < 150; e++) begin
      @(posedge aclk); #1;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL timeout_rel cyc %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_tiebreak();
    domain_idle = rand_not_idle();
    soft_rst_req = 1'b1;
    @(posedge aclk); #1;
    soft_rst_req = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      @(posedge aclk); #1;
      domain_idle = (k == 255) ? '1 : rand_not_idle();
    end
    @(posedge aclk); #1;
    n_tests++;
    if ({soft_rst_ack, drain_timeout} !== 2'b10) begin
      n_fail++;
      $display("FAIL tiebreak: got %b expected 10", {soft_rst_ack, drain_timeout});
    end
    for (int e = 0; e < 150; e++) begin
      @(posedge aclk); #1;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL tiebreak_rel cyc %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 3000; e++) begin
      @(posedge aclk); #1;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b expected %b", e, obs_vec, exp_vec);
      end
      soft_rst_req = ($urandom_range(0, 7) == 0);
      domain_idle  = $urandom_range(0, 1) ? '1 : N'($urandom);
      if (aresetn == 1'b0) aresetn = 1'b1;
      else if ($urandom_range(0, 599) == 0) aresetn = 1'b0;
    end
    aresetn = 1'b1;
    soft_rst_req = 1'b0;
  endtask

  task automatic test_small();
    aresetn_s = 1'b0;
    soft_s = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn_s = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge aclk); #1;
      if (e == 9) soft_s = 1'b0;
      n_tests++;
      if ({rst_s, all_s, ack_s, tmo_s} !== {(e >= 10), (e >= 11), 2'b00}) begin
        n_fail++;
        $display("FAIL small cyc %0d: got %b expected %b", e + 1, {rst_s, all_s, ack_s, tmo_s},
                 {(e >= 10), (e >= 11), 2'b00});
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_mid_release();
    test_soft_idle();
    test_soft_timeout();
    test_tiebreak();
    test_random();
    test_small();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_reset_seq.md
Name: cpu_reset_seq

Overview:
- Parametrised reset sequencer for the CPU subsystem; replaces the fixed 7-bit reset-stretch counter in the CPU top.
- Stretches the external aresetn, then releases N reset domains in a fixed staggered order. Typical domains: cache/AXI, TLB, CP0, core.
- Adds a software-requested warm reset. Before re-asserting resets, the block waits for every domain to report idle, or for a timeout.

Parameters:
- NUM_DOMAINS, 4: number of independently released reset outputs (1..8).
- STRETCH_W, 7: stretch counter width; resets are held 2^STRETCH_W cycles after synchronised release.
- STAGE_GAP, 4: cycles between consecutive domain releases (>=1).
- SYNC_STAGES, 2: reset-deassert synchroniser depth (>=2).
- TIMEOUT_W, 8: drain timeout counter width; timeout after 2^TIMEOUT_W cycles.

Ports:
- aclk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised internally
- soft_rst_req  in  1  warm-reset request, level or pulse, sampled each cycle
- domain_idle  in  NUM_DOMAINS  per-domain quiescent flag (for example mem_idle from the cache)
- rst_n_o  out  NUM_DOMAINS  per-domain active-low reset; bit 0 is released first
- all_released  out  1  high only in RUN
- soft_rst_ack  out  1  one-cycle pulse on entry to ASSERT from DRAIN
- drain_timeout  out  1  one-cycle pulse when DRAIN exits by timeout
- busy  out  1  high in every state except RUN

Behaviour:
- Reset values: rst_n_o=0, all_released=0, soft_rst_ack=0, drain_timeout=0, busy=1, state=ASSERT, all counters 0.
- aresetn low forces the reset values asynchronously in any state, including mid-RELEASE and mid-DRAIN.
- Synchroniser: SYNC_STAGES flops, async-cleared by aresetn, shifting in 1. The FSM runs only when the last stage is 1. First stretch-count cycle = SYNC_STAGES cycles after the aresetn rising edge.
- ASSERT:
  - rst_n_o all 0; stretch_cnt increments each cycle, starting from 0.
  - When stretch_cnt == 2^STRETCH_W-1, go to RELEASE next cycle. ASSERT lasts exactly 2^STRETCH_W cycles.
  - stretch_cnt clears on exit.
- RELEASE:
  - dom_idx starts at 0 and gap_cnt starts at 0.
  - On the first RELEASE cycle, rst_n_o[0] is set (registered, visible the following cycle).
  - Domain k is set exactly k*STAGE_GAP cycles after domain 0. Released bits stay 1.
  - After domain NUM_DOMAINS-1 is set, go to RUN next cycle.
- RUN:
  - all_released=1, busy=0.
  - soft_rst_req=1 -> DRAIN next cycle; timeout counter cleared.
- DRAIN:
  - rst_n_o stays all 1; timeout_cnt increments each cycle.
  - If &domain_idle, go to ASSERT next cycle and pulse soft_rst_ack.
  - Else if timeout_cnt == 2^TIMEOUT_W-1, go to ASSERT and pulse both soft_rst_ack and drain_timeout.
  - If idle and timeout happen in the same cycle, the idle exit wins: drain_timeout stays 0.
- Register timing: on entry to ASSERT, rst_n_o goes to all 0 on the same edge that registers the state change (synchronous assertion). The stretch then restarts from 0.
- soft_rst_req is ignored in ASSERT, RELEASE and DRAIN; no queuing, no ack. A request held high through the whole sequence re-triggers DRAIN on the first RUN cycle.
- Counter rollover:
  - stretch_cnt never wraps, because it is compared before wrap.
  - dom_idx is sized $clog2(NUM_DOMAINS)+1.
  - gap_cnt is sized $clog2(STAGE_GAP)+1 and resets to 0 after each release.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Package cpu_reset_pkg:
  - enum rst_state_t {ASSERT, RELEASE, RUN, DRAIN} (2 bits);
  - localparam default constants.
- Sub-module reset_sync: SYNC_STAGES-deep async-assert/sync-deassert synchroniser, reusable for other clock domains.
- FSM and counters stay in cpu_reset_seq.

Test Plan:
- Power-on, defaults: aresetn rises at cycle 0 -> rst_n_o=0000 through cycle 2+128-1; bit 0 rises at cycle 131. Bits 1/2/3 rise at 135/139/143; all_released=1 at 144.
- Async assert mid-RELEASE: drop aresetn while rst_n_o=0011 -> all outputs return to reset values within the same cycle (no clock edge). Re-release repeats the full 128-cycle stretch.
- Soft reset, idle: in RUN, pulse soft_rst_req 1 cycle with domain_idle=1111 -> DRAIN for 1 cycle, then soft_rst_ack=1 and drain_timeout=0. rst_n_o=0000 for 128 cycles, followed by the staggered release.
- Soft reset, timeout: domain_idle=0111 held -> exactly 256 DRAIN cycles, then soft_rst_ack=1 and drain_timeout=1 together.
- Tie-break: domain_idle becomes 1111 on the same cycle timeout_cnt=255 -> soft_rst_ack=1, drain_timeout=0.
- Parametrised build NUM_DOMAINS=1, STRETCH_W=3, STAGE_GAP=1: aresetn rises at 0 -> rst_n_o[0] rises at cycle 11; all_released at 12. soft_rst_req asserted during ASSERT produces no ack.
